// File: rtl/fp_mult_arbiter_if.sv
// Request/response bundle between the requesters, the shared multiplier
// and the result consumer.
interface fp_mult_arbiter_if #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*32-1:0] req_opd1;
  logic [NREQ*32-1:0] req_opd2;
  logic [NREQ-1:0]    req_ready;
  logic               resp_valid;
  logic               resp_ready;
  logic [IDW-1:0]     resp_id;
  logic [31:0]        resp_res;
  logic               resp_ovf;
  logic               busy;

  modport slave (
    input  req_valid, req_opd1, req_opd2, resp_ready,
    output req_ready, resp_valid, resp_id, resp_res, resp_ovf, busy
  );

  modport master (
    output req_valid, req_opd1, req_opd2, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_res, resp_ovf, busy
  );
endinterface

// File: rtl/fp_mult_arbiter.sv
// Round-robin arbiter sharing one combinational single-precision multiplier
// between NREQ requesters, with a two-stage operand/result pipeline.

module fp_mult (
  input  logic [31:0] opd1,
  input  logic [31:0] opd2,
  output logic [31:0] res,
  output logic        overflow
);
  logic        sign, nan_in, inf_in, zero_in, rnd;
  logic [47:0] prod;
  logic [22:0] mant;
  logic        guard, sticky;
  logic [23:0] mr;
  logic [9:0]  exp_u;
  logic signed [9:0] exp_s;

  // Denormal inputs and results flush to zero; rounding is nearest-even.
  always_comb begin
    sign    = opd1[31] ^ opd2[31];
    nan_in  = (opd1[30:23] == 8'hFF && |opd1[22:0]) || (opd2[30:23] == 8'hFF && |opd2[22:0]);
    inf_in  = (opd1[30:23] == 8'hFF) || (opd2[30:23] == 8'hFF);
    zero_in = (opd1[30:23] == 8'h00) || (opd2[30:23] == 8'h00);
    prod    = {24'b0, 1'b1, opd1[22:0]} * {24'b0, 1'b1, opd2[22:0]};
    if (prod[47]) begin
      mant   = prod[46:24];
      guard  = prod[23];
      sticky = |prod[22:0];
    end else begin
      mant   = prod[45:23];
      guard  = prod[22];
      sticky = |prod[21:0];
    end
    rnd   = guard & (sticky | mant[0]);
    mr    = {1'b0, mant} + {23'b0, rnd};
    exp_u = {2'b0, opd1[30:23]} + {2'b0, opd2[30:23]} + {9'b0, prod[47]}
          + {9'b0, mr[23]} - 10'd127;
    exp_s = $signed(exp_u);
    res      = {sign, exp_u[7:0], mr[22:0]};
    overflow = 1'b0;
    if (nan_in || (inf_in && zero_in)) begin
      res = 32'h7FC00000;
    end else if (inf_in) begin
      res = {sign, 8'hFF, 23'b0};
    end else if (zero_in) begin
      res = {sign, 31'b0};
    end else if (exp_s >= 10'sd255) begin
      res      = {sign, 8'hFF, 23'b0};
      overflow = 1'b1;
    end else if (exp_s <= 10'sd0) begin
      res = {sign, 31'b0};
    end
  end
endmodule

module fp_mult_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic             clk,
  input  logic             rst,
  fp_mult_arbiter_if.slave bus
);
  logic           s1_v_q, s1_v_d;
  logic [IDW-1:0] s1_id_q, s1_id_d;
  logic [31:0]    s1_a_q, s1_a_d, s1_b_q, s1_b_d;
  logic           resp_valid_q, resp_valid_d;
  logic [IDW-1:0] resp_id_q, resp_id_d;
  logic [31:0]    resp_res_q, resp_res_d;
  logic           resp_ovf_q, resp_ovf_d;
  logic [IDW-1:0] ptr_q, ptr_d;

  logic            s2_free, s1_free;
  logic            grant_vld;
  logic [IDW-1:0]  grant_id;
  logic [NREQ-1:0] grant_oh;
  logic [31:0]     sel_a, sel_b, mul_res;
  logic            mul_ovf;

  fp_mult u_mult (
    .opd1    (s1_a_q),
    .opd2    (s1_b_q),
    .res     (mul_res),
    .overflow(mul_ovf)
  );

  assign s2_free = !resp_valid_q || bus.resp_ready;
  assign s1_free = !s1_v_q || s2_free;

  // Walk from ptr upward; iterating in reverse leaves the nearest hit last.
  always_comb begin
    int idx;
    idx       = 0;
    grant_vld = 1'b0;
    grant_id  = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = int'(ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (bus.req_valid[IDW'(idx)]) begin
        grant_vld = 1'b1;
        grant_id  = IDW'(idx);
      end
    end
  end

  always_comb begin
    grant_oh = '0;
    sel_a    = '0;
    sel_b    = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_vld && grant_id == IDW'(i)) begin
        grant_oh[i] = 1'b1;
        sel_a       = bus.req_opd1[32*i +: 32];
        sel_b       = bus.req_opd2[32*i +: 32];
      end
    end
  end

  always_comb begin
    s1_v_d       = s1_v_q;
    s1_id_d      = s1_id_q;
    s1_a_d       = s1_a_q;
    s1_b_d       = s1_b_q;
    resp_valid_d = resp_valid_q;
    resp_id_d    = resp_id_q;
    resp_res_d   = resp_res_q;
    resp_ovf_d   = resp_ovf_q;
    ptr_d        = ptr_q;
    if (s2_free) begin
      resp_valid_d = s1_v_q;
      resp_id_d    = s1_id_q;
      resp_res_d   = mul_res;
      resp_ovf_d   = mul_ovf;
    end
    if (s1_free) begin
      s1_v_d = grant_vld;
      if (grant_vld) begin
        s1_id_d = grant_id;
        s1_a_d  = sel_a;
        s1_b_d  = sel_b;
        // Explicit wrap keeps ptr in range when NREQ is not a power of two.
        ptr_d   = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + IDW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v_q       <= 1'b0;
      s1_id_q      <= '0;
      s1_a_q       <= '0;
      s1_b_q       <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_res_q   <= '0;
      resp_ovf_q   <= 1'b0;
      ptr_q        <= '0;
    end else begin
      s1_v_q       <= s1_v_d;
      s1_id_q      <= s1_id_d;
      s1_a_q       <= s1_a_d;
      s1_b_q       <= s1_b_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_res_q   <= resp_res_d;
      resp_ovf_q   <= resp_ovf_d;
      ptr_q        <= ptr_d;
    end
  end

  assign bus.req_ready  = rst ? '0 : (grant_oh & {NREQ{s1_free}});
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_id    = resp_id_q;
  assign bus.resp_res   = resp_res_q;
  assign bus.resp_ovf   = resp_ovf_q;
  assign bus.busy       = s1_v_q | resp_valid_q;
endmodule
